imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: fills a writable imem from a byte stream before the LEGv8 core runs.
- Sits between a byte source (UART receiver or bench driver) and the imem write port.
- Holds the core in reset while loading and releases it once the last word is committed.
- Assembles little-endian bytes into N-bit words and writes them to consecutive addresses starting at 0.

Parameters:
- N, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_W, 6, imem address width; depth is 2**ADDR_W words (64).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle. A transfer is in_valid && in_ready.
- we  out  1  imem write enable; one-cycle pulse per word.
- waddr  out  ADDR_W  imem write address.
- wdata  out  N  imem write data.
- cpu_hold  out  1  holds the core in reset while high.
- busy  out  1  load in progress.
- done  out  1  last load completed; sticky until the next accepted start or reset.
- err  out  1  checksum mismatch; exists only with LOADER_CHECKSUM_EN. Sticky until the next accepted start or reset.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=0, we=0, waddr=0, wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0.
  - All byte and word counters 0.
- States:
  - IDLE → HDR on start.
  - HDR: in_ready=1. The first transfer is the word count C (8 bits).
    - C=0 loads 2**ADDR_W words.
    - If C > 2**ADDR_W, C is clamped to 2**ADDR_W and the excess bytes are still consumed but not written.
    - → DATA.
  - DATA: in_ready=1 except in the write cycle.
    - Byte k of a word (k=0..N/8-1) goes to wdata[8k+7:8k], least significant byte first.
    - After the last byte of a word is accepted, the next cycle drives we=1 with waddr = word index, and in_ready=0 in that cycle.
    - waddr increments after each write.
    - After the C-th write (or after the excess bytes when clamped): → CHK if LOADER_CHECKSUM_EN is defined, otherwise → DONE.
  - CHK: in_ready=1. One transfer, the checksum byte. → DONE.
  - DONE: cpu_hold=0, done=1, in_ready=0. start → HDR.
- busy=1 in HDR, DATA and CHK. cpu_hold=1 in every state except DONE.
- Accepted start:
  - Clears done and err.
  - Asserts cpu_hold in the next cycle.
  - Resets the address and byte counters to 0.
- Write latency: we rises exactly one cycle after the transfer of the last byte of a word.
- Byte stalls (in_valid=0) at any point only hold state; no timeout.
- start while busy: ignored.
- start in the same cycle as a DONE transition: ignored; a new start pulse is needed.
- waddr wraps at 2**ADDR_W. This is unreachable because of the clamp, but the address counter is ADDR_W+1 bits internally so that a full 64-word count terminates correctly.
- Reset asserted mid-load:
  - Returns immediately to the reset values.
  - Words already written stay in the imem.
  - No partial write is issued.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The stream carries a trailing byte equal to the XOR of the header byte and all data bytes.
  - On mismatch, err=1 and the loader still enters DONE, but cpu_hold stays 1 until the next start or reset.
  - On match, err=0.
- Undefined:
  - No CHK state and no err port.
  - DONE follows the last write directly.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum typedef (IDLE, HDR, DATA, CHK, DONE);
  - the byte width constant 8;
  - the header clamp constant.
- One sub-module, word_assembler:
  - shift/lane register with a byte counter;
  - emits word_valid for one cycle when N/8 bytes have been collected;
  - cleared on start.
- The FSM, address counter and checksum live in imem_loader.

Test Plan:
- Header 0x02, then bytes 01 00 00 F8, 02 80 00 F8 with in_valid always high:
  - we pulses at waddr=0 with wdata=0xF8000001;
  - we pulses at waddr=1 with wdata=0xF8008002;
  - done=1 and cpu_hold=0 one cycle after the second write.
- Same stream with in_valid low for 3 cycles between each byte: identical writes and data; no extra we pulses.
- Header 0x00 followed by 256 bytes of incrementing pattern:
  - 64 writes, last at waddr=63;
  - done asserts after the 64th write;
  - a 65th word is never written.
- Reset driven low after 1.5 words of a 3-word load:
  - all outputs return to reset values asynchronously;
  - a new start plus a full 3-word stream loads correctly from waddr=0.
- start pulsed while busy in DATA: no effect on the address sequence; done asserts only once.
- With LOADER_CHECKSUM_EN, header 0x01, data 01 00 00 F8:
  - checksum 0xF8 gives err=0 and cpu_hold=0;
  - checksum 0x00 gives err=1 and cpu_hold=1 in DONE.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem byte-stream loader.
package imem_loader_pkg;

  localparam int BYTE_W = 8;

  // Header values of 0 or above this word count load exactly this many words.
  localparam int HDR_CLAMP = 64;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    DONE
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into an N-bit word; word_vld pulses the cycle after the last byte lands.
// No backpressure of its own: the parent gates byte_vld.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic              word_vld,
  output logic [N-1:0]      word_dat
);

  localparam int LANES = N / BYTE_W;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic [CW-1:0] lane;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane     <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (clear) begin
      lane     <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        word_dat[lane*BYTE_W +: BYTE_W] <= byte_dat;
        if (lane == LAST_LANE) begin
          lane     <= '0;
          word_vld <= 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads imem from a header+data byte stream, holding the core in reset; write lands one cycle after a word's last byte,
// in_ready drops during that write cycle. Optional trailing XOR checksum enabled by LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(HDR_CLAMP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic              err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t          state;
  logic [ADDR_W:0] addr_cnt;
  logic [8:0]      total;
  logic [8:0]      seen;
  logic            word_vld;
  logic [N-1:0]    word_dat;
  logic            xfer;
  logic            start_ok;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  word_assembler #(.N(N)) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .byte_vld (xfer && (state == DATA)),
    .byte_dat (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // Words past the imem depth still occupy a write slot but never assert we.
  assign we       = word_vld && !addr_cnt[ADDR_W];
  assign waddr    = addr_cnt[ADDR_W-1:0];
  assign wdata    = word_dat;
  assign in_ready = (state == HDR) || (state == CHK) || ((state == DATA) && !word_vld);
  assign busy     = (state == HDR) || (state == DATA) || (state == CHK);
  assign done     = (state == DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  assign cpu_hold = !((state == DONE) && !err);
`else
  assign cpu_hold = (state != DONE);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_cnt <= '0;
      total    <= '0;
      seen     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= HDR;
            addr_cnt <= '0;
            seen     <= '0;
`ifdef LOADER_CHECKSUM_EN
            err      <= 1'b0;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            total <= (in_data == '0) ? 9'(DEPTH) : {1'b0, in_data};
            state <= DATA;
`ifdef LOADER_CHECKSUM_EN
            csum  <= in_data;
`endif
          end
        end
        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer) csum <= csum ^ in_data;
`endif
          if (word_vld) begin
            if (we) addr_cnt <= addr_cnt + 1'b1;
            seen <= seen + 9'd1;
            if (seen == total - 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            err   <= (in_data != csum);
            state <= DONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: basic, stalled, full-depth, clamp, reset and start-while-busy loads.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int N = 32;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, we, cpu_hold, busy, done;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0] wdata;
`ifdef LOADER_CHECKSUM_EN
  logic err;
`endif

  int errors = 0;
  int checks = 0;

  int wr_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [ADDR_W-1:0] log_addr [0:1023];
  logic [N-1:0] log_data [0:1023];

  always #5 clk = ~clk;

  imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .err      (err)
`endif
  );

  // Write log and done-edge counter, sampled away from the active edge.
  always @(negedge clk) begin
    if (we === 1'b1 && wr_cnt < 1024) begin
      log_addr[wr_cnt] = waddr;
      log_data[wr_cnt] = wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (done === 1'b1 && prev_done === 1'b0) done_cnt = done_cnt + 1;
    prev_done = done;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, cpu_hold, done} !== 3'b110) begin
      errors++;
      $display("FAIL start_state: busy/cpu_hold/done=%b required 110", {busy, cpu_hold, done});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, we, cpu_hold, busy, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: in_ready/we/cpu_hold/busy/done=%b required 00100",
               {in_ready, we, cpu_hold, busy, done});
    end
    checks++;
    if (waddr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: waddr=%h wdata=%h required 0/0", waddr, wdata);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, cpu_hold} !== 3'b001) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready/busy/cpu_hold=%b required 001", {in_ready, busy, cpu_hold});
    end
  endtask

  task automatic test_two_words(input int gap);
    int base, d0;
    base = wr_cnt;
    d0 = done_cnt;
    do_start();
    send_byte(8'h02, gap);
    send_word(32'hF800_0001, gap);
    send_word(32'hF800_8002, gap);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || waddr !== 6'd1 || wdata !== 32'hF800_8002 || done !== 1'b0) begin
      errors++;
      $display("FAIL two_words_gap%0d_last_write: we=%b waddr=%0d wdata=%h done=%b required 1/1/f8008002/0",
               gap, we, waddr, wdata, done);
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_hold, busy, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL two_words_gap%0d_done: done/cpu_hold/busy/in_ready=%b required 1000",
               gap, {done, cpu_hold, busy, in_ready});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 2 || log_addr[base] !== 6'd0 || log_data[base] !== 32'hF800_0001 ||
        log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'hF800_8002) begin
      errors++;
      $display("FAIL two_words_gap%0d_log: writes=%0d first=%0d:%h second=%0d:%h required 2 0:f8000001 1:f8008002",
               gap, wr_cnt - base, log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL two_words_gap%0d_done_count: got %0d required 1", gap, done_cnt - d0);
    end
  endtask

  // hdr selects the header byte; nwords words are streamed, the first 64 must land in imem.
  task automatic test_bulk(input logic [7:0] hdr, input int nwords, input logic incr);
    int base, bad;
    logic [7:0] b0;
    logic [31:0] w, exp_last;
    base = wr_cnt;
    do_start();
    send_byte(hdr, 0);
    for (int i = 0; i < nwords; i++) begin
      b0 = 8'(4 * i);
      w = incr ? {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0} : {4{8'(i)}};
      send_word(w, 0);
    end
    exp_last = incr ? 32'hFFFE_FDFC : {4{8'd63}};
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hAA;
    checks++;
    if (nwords == 64 && (we !== 1'b1 || waddr !== 6'd63 || wdata !== exp_last)) begin
      errors++;
      $display("FAIL bulk_hdr%h_last_write: we=%b waddr=%0d wdata=%h required 1/63/%h", hdr, we, waddr, wdata, exp_last);
    end else if (nwords > 64 && we !== 1'b0) begin
      errors++;
      $display("FAIL bulk_hdr%h_excess_write: we=%b required 0", hdr, we);
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL bulk_hdr%h_done: done/cpu_hold=%b required 10", hdr, {done, cpu_hold});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || wr_cnt - base !== 64) begin
      errors++;
      $display("FAIL bulk_hdr%h_count: in_ready=%b writes=%0d required 0/64", hdr, in_ready, wr_cnt - base);
    end
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      b0 = 8'(4 * i);
      w = incr ? {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0} : {4{8'(i)}};
      if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== w) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bulk_hdr%h_contents: %0d bad writes, required 0", hdr, bad);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    base = wr_cnt;
    do_start();
    send_byte(8'h03, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, we, cpu_hold, busy, done} !== 5'b00100 || waddr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL midload_reset: flags=%b waddr=%h wdata=%h required 00100/0/0",
               {in_ready, we, cpu_hold, busy, done}, waddr, wdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 1 || log_data[base] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL midload_partial: writes=%0d first=%h required 1/11223344", wr_cnt - base, log_data[base]);
    end
    reset = 1'b1;
    base = wr_cnt;
    do_start();
    send_byte(8'h03, 0);
    send_word(32'hA1A2_A3A4, 0);
    send_word(32'hB1B2_B3B4, 0);
    send_word(32'hC1C2_C3C4, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 3 || log_addr[base] !== 6'd0 || log_data[base] !== 32'hA1A2_A3A4 ||
        log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'hB1B2_B3B4 ||
        log_addr[base+2] !== 6'd2 || log_data[base+2] !== 32'hC1C2_C3C4 || done !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_reset: writes=%0d a0=%0d d0=%h a2=%0d d2=%h done=%b required 3 0 a1a2a3a4 2 c1c2c3c4 1",
               wr_cnt - base, log_addr[base], log_data[base], log_addr[base+2], log_data[base+2], done);
    end
  endtask

  task automatic test_start_busy();
    int base, d0;
    base = wr_cnt;
    d0 = done_cnt;
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'hF8, 0);
    send_word(32'hF800_8002, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL start_busy_state: busy/done=%b required 01", {busy, done});
    end
    checks++;
    if (wr_cnt - base !== 2 || log_addr[base] !== 6'd0 || log_data[base] !== 32'hF800_0001 ||
        log_addr[base+1] !== 6'd1 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL start_busy_seq: writes=%0d a0=%0d d0=%h a1=%0d dones=%0d required 2 0 f8000001 1 1",
               wr_cnt - base, log_addr[base], log_data[base], log_addr[base+1], done_cnt - d0);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] cs, input logic exp_err);
    do_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL checksum_clear_on_start: err=%b required 0", err);
    end
    send_byte(8'h01, 0);
    send_word(32'hF800_0001, 0);
    send_byte(cs, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({done, err, cpu_hold} !== {1'b1, exp_err, exp_err}) begin
      errors++;
      $display("FAIL checksum_%h: done/err/cpu_hold=%b required %b", cs, {done, err, cpu_hold},
               {1'b1, exp_err, exp_err});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words(0);
    test_two_words(3);
    test_bulk(8'h00, 64, 1'b1);
    test_bulk(8'h41, 65, 1'b0);
    test_reset_midload();
    test_start_busy();
`ifdef LOADER_CHECKSUM_EN
    test_checksum(8'hF8, 1'b0);
    test_checksum(8'h00, 1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
